uart_framed_core: RTL and testbench
===================================

# uart_framed_core

Parametrised UART serial engine: one transmitter and one receiver sharing a bit-rate setting, with runtime-selectable data width (5..MAX_DATA_BITS), parity (none/even/odd) and one or two stop bits. Reports parity, framing and break conditions per received character. It sits between the UART peripheral's FIFOs and the pads. It supersedes the fixed 8N1 rx/tx pair, and its framing options and error flags are exposed through the peripheral's configuration and status registers.

## Interface
- CLOCK_SCALE_BITS, 16, width of cyclesPerBit.
- MAX_DATA_BITS, 9, widest character supported; legal values 8 or 9.
- clk  in  1  system clock; everything is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  core enable.
- cyclesPerBit  in  CLOCK_SCALE_BITS  bit period minus one.
- dataBits  in  4  character length.
- parityMode  in  2  parity selection: 0 none, 1 even, 2 odd, 3 treated as none.
- twoStopBits  in  1  transmit two stop bits.
- txData  in  MAX_DATA_BITS  character to send; LSB first; bits above dataBits ignored.
- txValid  in  1  txData is offered.
- txReady  out  1  transmitter accepts txData this cycle.
- txBusy  out  1  frame in progress on tx.
- tx  out  1  serial output; idle high.
- rx  in  1  serial input; asynchronous.
- rxData  out  MAX_DATA_BITS  received character, zero-extended.
- rxValid  out  1  one-cycle pulse: rxData and the error flags are valid.
- rxParityError  out  1  parity mismatch; qualified by rxValid.
- rxFramingError  out  1  first stop bit sampled low; qualified by rxValid.
- rxBreak  out  1  break detected; qualified by rxValid.
- rxBusy  out  1  receiver is not in IDLE.

## Operation
- Bit period is cyclesPerBit+1 clocks. cyclesPerBit values below 3 are used as 3.
- dataBits values below 5 are used as 5; values above MAX_DATA_BITS are used as MAX_DATA_BITS.
- Configuration latching:
  - The transmitter latches cyclesPerBit, dataBits, parityMode and twoStopBits on accept.
  - The receiver latches them on start-edge detection.
  - Configuration changes mid-frame do not affect that frame.
- Parity bit:
  - Even parity: XOR of the data bits.
  - Odd parity: the inverse of that XOR.
  - The parity bit is sent after the last data bit.
- TX state machine: IDLE -> START -> DATA -> PARITY (skipped if parity is none) -> STOP1 -> STOP2 (only if twoStopBits) -> IDLE.
- txReady = enable && state==IDLE && !rst. Accept happens when txValid && txReady.
- Deasserting enable mid-frame does not abort the frame; the current frame completes.
- rx passes through a 2-flop synchroniser. While enable=0 the synchronised value is forced to 1 and the receiver is held in IDLE.
- RX state machine: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE, or -> WAIT_HIGH.
  - IDLE -> START on a synchronised 1->0 edge.
  - In START, the line is sampled (cyclesPerBit+1)/2 clocks (integer divide) after the edge. If it is high, the event is a glitch: return to IDLE with no output.
  - Each following bit is sampled cyclesPerBit+1 clocks after the previous sample.
  - Only one stop bit is checked, regardless of twoStopBits.
- Framing and break:
  - Stop bit low -> rxFramingError.
  - If the data bits, the parity bit (if enabled) and the stop bit are all 0 -> rxBreak=1 and rxFramingError=1, with rxData=0.
  - After any framing error the receiver enters WAIT_HIGH. It returns to IDLE only after one synchronised high sample, so a held break yields exactly one rxValid.
- A parity error still delivers rxData with rxValid.

## Timing
- Reset values: tx=1, txReady=0, txBusy=0, rxData=0, rxValid=0, all error flags 0, rxBusy=0, both FSMs in IDLE.
- Reset mid-frame: tx=1 on the cycle after rst is sampled, and partial receive data is discarded.
- TX timing:
  - Accept at cycle T -> tx=0 from T+1.
  - Each bit lasts cyclesPerBit+1 cycles.
  - txBusy is high from T+1 until the last stop-bit cycle inclusive.
  - txReady re-asserts on the cycle after the last stop-bit cycle, and a back-to-back accept starts the next start bit on the next cycle. Stop bits therefore always last their full duration.
- RX latency:
  - rx edge to synchronised edge: 2 cycles.
  - rxValid pulses exactly one cycle, on the cycle after the stop-bit sample.
  - rxData and the error flags are registered and stable from that cycle until the next rxValid.

## Test plan
- TX 8N1, cyclesPerBit=3, txData=0xA5 accepted at T -> tx low T+1..T+4, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. txReady is low for exactly 40 cycles.
- Loopback tx->rx, 7 data bits, even parity, two stop bits, txData=0x55 -> parity bit 0, frame of 44 cycles, rxData=0x055, rxValid single pulse, no error flags.
- Odd parity, 8 bits, 0x0F with the parity bit forced to 0 by the bench -> rxData=0x0F, rxParityError=1 with rxValid, rxFramingError=0.
- 8N1, stop bit driven low -> rxFramingError=1, rxBreak=0. Then rx held low for 20 bit times -> exactly one further rxValid, with rxBreak=1 and rxData=0. No new frame until rx returns high and a new start bit arrives.
- rx low for 1 cycle only (cyclesPerBit=15) -> no rxValid, rxBusy returns to 0 within 10 cycles. A following valid frame of 0x3C is received correctly.
- rst asserted at the 3rd data bit of a TX frame and during a RX frame -> tx=1 next cycle, no rxValid. After rst is released, txReady=1 and the next frame is sent and received normally.

Source files
------------

// File: rtl/uart_framed_core.sv
// UART transmitter/receiver pair with runtime framing: 5..MAX_DATA_BITS data bits,
// none/even/odd parity, one or two stop bits, with parity/framing/break reporting.
module uart_framed_core #(
  parameter int CLOCK_SCALE_BITS = 16,
  parameter int MAX_DATA_BITS    = 9
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [CLOCK_SCALE_BITS-1:0] cyclesPerBit,
  input  logic [3:0]                  dataBits,
  input  logic [1:0]                  parityMode,
  input  logic                        twoStopBits,
  input  logic [MAX_DATA_BITS-1:0]    txData,
  input  logic                        txValid,
  output logic                        txReady,
  output logic                        txBusy,
  output logic                        tx,
  input  logic                        rx,
  output logic [MAX_DATA_BITS-1:0]    rxData,
  output logic                        rxValid,
  output logic                        rxParityError,
  output logic                        rxFramingError,
  output logic                        rxBreak,
  output logic                        rxBusy
);
  localparam int CW = CLOCK_SCALE_BITS;
  localparam int DW = MAX_DATA_BITS;
  localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_BITS);

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0, TX_START = 3'd1, TX_DATA = 3'd2,
    TX_PARITY = 3'd3, TX_STOP1 = 3'd4, TX_STOP2 = 3'd5
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE = 3'd0, RX_START = 3'd1, RX_DATA = 3'd2,
    RX_PARITY = 3'd3, RX_STOP = 3'd4, RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  function automatic logic [CW-1:0] clamp_period(input logic [CW-1:0] c);
    logic [CW-1:0] r;
    if (c < CW'(2'd3)) r = CW'(2'd3);
    else               r = c;
    return r;
  endfunction

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    logic [3:0] r;
    if (b < 4'd5)          r = 4'd5;
    else if (b > MAX_BITS) r = MAX_BITS;
    else                   r = b;
    return r;
  endfunction

  function automatic logic [DW-1:0] mask_data(input logic [DW-1:0] d, input logic [3:0] n);
    logic [DW-1:0] r;
    r = {DW{1'b0}};
    for (int i = 0; i < DW; i++) begin
      if (i < int'(n)) r[i] = d[i];
      else             r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic logic parity_bit(input logic [DW-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // ---------------- transmitter ----------------
  tx_state_t     r_tx_state, w_tx_next_state;
  logic [CW-1:0] r_tx_cnt, r_tx_period;
  logic [3:0]    r_tx_bit_idx, r_tx_nbits;
  logic [DW-1:0] r_tx_shift, w_tx_shift_next, w_tx_masked;
  logic          r_tx_par_en, r_tx_par_bit, r_tx_two_stop, r_tx;
  logic          w_tx_accept, w_tx_bit_end, w_tx_line;

  assign txReady      = enable && (r_tx_state == TX_IDLE) && !rst;
  assign w_tx_accept  = txValid && txReady;
  assign w_tx_bit_end = (r_tx_cnt == r_tx_period);
  assign w_tx_masked  = mask_data(txData, clamp_bits(dataBits));
  assign txBusy       = (r_tx_state != TX_IDLE);
  assign tx           = r_tx;

  always_comb begin
    w_tx_next_state = r_tx_state;
    w_tx_shift_next = r_tx_shift;
    w_tx_line       = 1'b1;
    case (r_tx_state)
      TX_IDLE: begin
        if (w_tx_accept) w_tx_next_state = TX_START;
        else             w_tx_next_state = TX_IDLE;
      end
      TX_START: begin
        if (w_tx_bit_end) w_tx_next_state = TX_DATA;
        else              w_tx_next_state = TX_START;
      end
      TX_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_shift_next = r_tx_shift >> 1;
          if (r_tx_bit_idx == r_tx_nbits - 4'd1)
            w_tx_next_state = r_tx_par_en ? TX_PARITY : TX_STOP1;
          else
            w_tx_next_state = TX_DATA;
        end else begin
          w_tx_next_state = TX_DATA;
        end
      end
      TX_PARITY: begin
        if (w_tx_bit_end) w_tx_next_state = TX_STOP1;
        else              w_tx_next_state = TX_PARITY;
      end
      TX_STOP1: begin
        if (w_tx_bit_end) w_tx_next_state = r_tx_two_stop ? TX_STOP2 : TX_IDLE;
        else              w_tx_next_state = TX_STOP1;
      end
      TX_STOP2: begin
        if (w_tx_bit_end) w_tx_next_state = TX_IDLE;
        else              w_tx_next_state = TX_STOP2;
      end
      default: w_tx_next_state = TX_IDLE;
    endcase
    // The line level is registered, so it is chosen from the state being entered.
    case (w_tx_next_state)
      TX_START:  w_tx_line = 1'b0;
      TX_DATA:   w_tx_line = w_tx_shift_next[0];
      TX_PARITY: w_tx_line = r_tx_par_bit;
      default:   w_tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_state <= TX_IDLE;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_next_state;
      r_tx       <= w_tx_line;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_cnt      <= {CW{1'b0}};
      r_tx_period   <= CW'(2'd3);
      r_tx_bit_idx  <= 4'd0;
      r_tx_nbits    <= 4'd8;
      r_tx_shift    <= {DW{1'b0}};
      r_tx_par_en   <= 1'b0;
      r_tx_par_bit  <= 1'b0;
      r_tx_two_stop <= 1'b0;
    end else if (w_tx_accept) begin
      r_tx_cnt      <= {CW{1'b0}};
      r_tx_period   <= clamp_period(cyclesPerBit);
      r_tx_nbits    <= clamp_bits(dataBits);
      r_tx_shift    <= w_tx_masked;
      r_tx_par_en   <= (parityMode == 2'd1) || (parityMode == 2'd2);
      r_tx_par_bit  <= parity_bit(w_tx_masked, parityMode == 2'd2);
      r_tx_two_stop <= twoStopBits;
    end else begin
      r_tx_shift <= w_tx_shift_next;
      if ((r_tx_state == TX_IDLE) || w_tx_bit_end) r_tx_cnt <= {CW{1'b0}};
      else                                         r_tx_cnt <= r_tx_cnt + CW'(1'b1);
      if (r_tx_state == TX_START)                  r_tx_bit_idx <= 4'd0;
      else if ((r_tx_state == TX_DATA) && w_tx_bit_end) r_tx_bit_idx <= r_tx_bit_idx + 4'd1;
      else                                         r_tx_bit_idx <= r_tx_bit_idx;
    end
  end

  // ---------------- receiver ----------------
  rx_state_t     r_rx_state, w_rx_fsm_next, w_rx_next_state;
  logic          r_rx_meta, r_rx_sync, r_rx_prev, w_rx_s, w_rx_fall, w_rx_sample;
  logic [CW-1:0] r_rx_cnt, r_rx_period;
  logic [CW:0]   w_rx_half_m1;
  logic [3:0]    r_rx_bit_idx, r_rx_nbits;
  logic [DW-1:0] r_rx_shift, w_rx_aligned;
  logic          r_rx_par_en, r_rx_par_odd, r_rx_par_bit, w_rx_break;
  logic [DW-1:0] r_rx_data;
  logic          r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_brk;

  assign w_rx_s       = enable ? r_rx_sync : 1'b1;
  assign w_rx_fall    = r_rx_prev && !w_rx_s;
  assign w_rx_half_m1 = (({1'b0, r_rx_period} + (CW+1)'(1'b1)) >> 1) - (CW+1)'(1'b1);
  assign w_rx_sample  = (r_rx_state == RX_START) ? ({1'b0, r_rx_cnt} == w_rx_half_m1)
                                                 : (r_rx_cnt == r_rx_period);
  // Bits are shifted in from the top, so the character lands MSB-aligned until shifted down.
  assign w_rx_aligned = r_rx_shift >> (4'(DW) - r_rx_nbits);
  assign w_rx_break   = !w_rx_s && (w_rx_aligned == {DW{1'b0}}) && (!r_rx_par_en || !r_rx_par_bit);

  assign rxData         = r_rx_data;
  assign rxValid        = r_rx_valid;
  assign rxParityError  = r_rx_perr;
  assign rxFramingError = r_rx_ferr;
  assign rxBreak        = r_rx_brk;
  assign rxBusy         = (r_rx_state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= w_rx_s;
    end
  end

  always_comb begin
    w_rx_fsm_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE: begin
        if (w_rx_fall) w_rx_fsm_next = RX_START;
        else           w_rx_fsm_next = RX_IDLE;
      end
      RX_START: begin
        if (!w_rx_sample) w_rx_fsm_next = RX_START;
        else if (w_rx_s)  w_rx_fsm_next = RX_IDLE;
        else              w_rx_fsm_next = RX_DATA;
      end
      RX_DATA: begin
        if (w_rx_sample && (r_rx_bit_idx == r_rx_nbits - 4'd1))
          w_rx_fsm_next = r_rx_par_en ? RX_PARITY : RX_STOP;
        else
          w_rx_fsm_next = RX_DATA;
      end
      RX_PARITY: begin
        if (w_rx_sample) w_rx_fsm_next = RX_STOP;
        else             w_rx_fsm_next = RX_PARITY;
      end
      RX_STOP: begin
        if (!w_rx_sample) w_rx_fsm_next = RX_STOP;
        else if (w_rx_s)  w_rx_fsm_next = RX_IDLE;
        else              w_rx_fsm_next = RX_WAIT_HIGH;
      end
      RX_WAIT_HIGH: begin
        if (w_rx_s) w_rx_fsm_next = RX_IDLE;
        else        w_rx_fsm_next = RX_WAIT_HIGH;
      end
      default: w_rx_fsm_next = RX_IDLE;
    endcase
    if (enable) w_rx_next_state = w_rx_fsm_next;
    else        w_rx_next_state = RX_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) r_rx_state <= RX_IDLE;
    else     r_rx_state <= w_rx_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_cnt     <= {CW{1'b0}};
      r_rx_period  <= CW'(2'd3);
      r_rx_bit_idx <= 4'd0;
      r_rx_nbits   <= 4'd8;
      r_rx_shift   <= {DW{1'b0}};
      r_rx_par_en  <= 1'b0;
      r_rx_par_odd <= 1'b0;
      r_rx_par_bit <= 1'b0;
      r_rx_data    <= {DW{1'b0}};
      r_rx_valid   <= 1'b0;
      r_rx_perr    <= 1'b0;
      r_rx_ferr    <= 1'b0;
      r_rx_brk     <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (!enable) begin
        r_rx_cnt <= {CW{1'b0}};
      end else begin
        case (r_rx_state)
          RX_IDLE: begin
            r_rx_cnt <= {CW{1'b0}};
            if (w_rx_fall) begin
              r_rx_period  <= clamp_period(cyclesPerBit);
              r_rx_nbits   <= clamp_bits(dataBits);
              r_rx_par_en  <= (parityMode == 2'd1) || (parityMode == 2'd2);
              r_rx_par_odd <= (parityMode == 2'd2);
              r_rx_shift   <= {DW{1'b0}};
              r_rx_bit_idx <= 4'd0;
            end else begin
              r_rx_bit_idx <= 4'd0;
            end
          end
          RX_START, RX_DATA, RX_PARITY, RX_STOP: begin
            if (w_rx_sample) r_rx_cnt <= {CW{1'b0}};
            else             r_rx_cnt <= r_rx_cnt + CW'(1'b1);
            if (w_rx_sample && (r_rx_state == RX_DATA)) begin
              r_rx_shift   <= {w_rx_s, r_rx_shift[DW-1:1]};
              r_rx_bit_idx <= r_rx_bit_idx + 4'd1;
            end else begin
              r_rx_bit_idx <= r_rx_bit_idx;
            end
            if (w_rx_sample && (r_rx_state == RX_PARITY)) r_rx_par_bit <= w_rx_s;
            else                                          r_rx_par_bit <= r_rx_par_bit;
            if (w_rx_sample && (r_rx_state == RX_STOP)) begin
              r_rx_valid <= 1'b1;
              r_rx_data  <= w_rx_aligned;
              r_rx_perr  <= r_rx_par_en && (parity_bit(w_rx_aligned, r_rx_par_odd) != r_rx_par_bit);
              r_rx_ferr  <= !w_rx_s;
              r_rx_brk   <= w_rx_break;
            end else begin
              r_rx_valid <= 1'b0;
            end
          end
          default: r_rx_cnt <= {CW{1'b0}};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_framed_core.sv
// Scoreboard bench for uart_framed_core: random loopback frames plus directed parity,
// framing/break, glitch, enable-drop and mid-frame reset scenarios.
`timescale 1ns/1ps
module tb_uart_framed_core;
  logic        clk = 1'b0;
  logic        rst, enable, twoStopBits, txValid, txReady, txBusy, tx, rx;
  logic        rxValid, rxParityError, rxFramingError, rxBreak, rxBusy;
  logic [15:0] cyclesPerBit;
  logic [3:0]  dataBits;
  logic [1:0]  parityMode;
  logic [8:0]  txData, rxData;
  logic        loop_en, rx_drv;
  logic        prev_valid = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct packed { logic [8:0] d; logic pe; logic fe; logic brk; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  assign rx = loop_en ? tx : rx_drv;

  uart_framed_core #(.CLOCK_SCALE_BITS(16), .MAX_DATA_BITS(9)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cyclesPerBit(cyclesPerBit),
    .dataBits(dataBits), .parityMode(parityMode), .twoStopBits(twoStopBits),
    .txData(txData), .txValid(txValid), .txReady(txReady), .txBusy(txBusy), .tx(tx),
    .rx(rx), .rxData(rxData), .rxValid(rxValid), .rxParityError(rxParityError),
    .rxFramingError(rxFramingError), .rxBreak(rxBreak), .rxBusy(rxBusy)
  );

  // ---------------- reference model ----------------
  function automatic int m_period(input int c);
    return ((c < 3) ? 3 : c) + 1;
  endfunction

  function automatic int m_bits(input int b);
    if (b < 5) return 5;
    if (b > 9) return 9;
    return b;
  endfunction

  function automatic logic [8:0] m_mask(input logic [8:0] d, input int n);
    return d & 9'((1 << n) - 1);
  endfunction

  function automatic bit m_has_par(input int mode);
    return (mode == 1) || (mode == 2);
  endfunction

  function automatic logic m_par(input logic [8:0] d, input int n, input int mode);
    int ones;
    ones = $countones(m_mask(d, n));
    if (mode == 2) return (ones % 2) == 0;
    return (ones % 2) != 0;
  endfunction

  function automatic int m_frame(input logic [8:0] d, input int n, input int mode, input int two,
                                 input logic pbit, input logic sbit, output logic [15:0] bits);
    int k;
    bits = 16'hFFFF;
    bits[0] = 1'b0;
    k = 1;
    for (int i = 0; i < n; i++) begin bits[k] = d[i]; k++; end
    if (m_has_par(mode)) begin bits[k] = pbit; k++; end
    bits[k] = sbit; k++;
    if (two != 0) begin bits[k] = 1'b1; k++; end
    return k;
  endfunction

  function automatic exp_t m_expect(input logic [8:0] d, input int n, input int mode,
                                    input logic pbit, input logic sbit);
    exp_t e;
    logic [8:0] md;
    md    = m_mask(d, n);
    e.brk = !sbit && (md == 9'd0) && (!m_has_par(mode) || !pbit);
    e.fe  = !sbit;
    e.d   = e.brk ? 9'd0 : md;
    e.pe  = m_has_par(mode) && (pbit != m_par(d, n, mode));
    return e;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: every rxValid pops one expected character.
  always @(negedge clk) begin
    if (rxValid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL rx_unexpected: got data=%h pe=%b fe=%b brk=%b, required no rxValid",
                 rxData, rxParityError, rxFramingError, rxBreak);
      end else begin
        mon_e = exp_q.pop_front();
        if ({rxData, rxParityError, rxFramingError, rxBreak, prev_valid} !==
            {mon_e.d, mon_e.pe, mon_e.fe, mon_e.brk, 1'b0}) begin
          n_bad++;
          $display("FAIL rx_char: got data=%h pe=%b fe=%b brk=%b repeat=%b, required data=%h pe=%b fe=%b brk=%b repeat=0",
                   rxData, rxParityError, rxFramingError, rxBreak, prev_valid,
                   mon_e.d, mon_e.pe, mon_e.fe, mon_e.brk);
        end
      end
    end
    prev_valid <= rxValid;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int c, input int b, input int pm, input int two);
    cyclesPerBit = 16'(c);
    dataBits     = 4'(b);
    parityMode   = 2'(pm);
    twoStopBits  = 1'(two);
  endtask

  task automatic send_check(input logic [8:0] d, input bit push, input bit drop_en);
    logic [15:0] bits, sv_c;
    logic [3:0]  sv_b;
    logic [1:0]  sv_pm;
    logic        sv_two;
    int nb, p, n, mode, guard, errs, ready_low;
    n    = m_bits(int'(dataBits));
    mode = int'(parityMode);
    p    = m_period(int'(cyclesPerBit));
    nb   = m_frame(d, n, mode, int'(twoStopBits), m_par(d, n, mode), 1'b1, bits);
    sv_c = cyclesPerBit; sv_b = dataBits; sv_pm = parityMode; sv_two = twoStopBits;
    txData = d; txValid = 1'b1; guard = 0;
    @(negedge clk);
    while (!txReady && guard < 5000) begin @(negedge clk); guard++; end
    check("tx_ready_wait", {31'd0, txReady}, 32'd1);
    @(posedge clk); #1;
    txValid = 1'b0;
    txData  = 9'($urandom);
    if (push) exp_q.push_back(m_expect(d, n, mode, m_par(d, n, mode), 1'b1));
    if (drop_en) begin
      enable = 1'b0;
      set_cfg($urandom_range(0, 20), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
    end
    errs = 0; ready_low = 0;
    for (int k = 0; k < nb * p; k++) begin
      @(negedge clk);
      if ((tx !== bits[k / p]) || (txBusy !== 1'b1)) errs++;
      if (txReady !== 1'b1) ready_low++;
    end
    check("tx_waveform_errors", errs, 32'd0);
    check("tx_ready_low_cycles", ready_low, nb * p);
    @(negedge clk);
    check("tx_after_frame", {29'd0, tx, txBusy, txReady}, {29'd0, 1'b1, 1'b0, enable});
    @(posedge clk); #1;
    enable = 1'b1;
    cyclesPerBit = sv_c; dataBits = sv_b; parityMode = sv_pm; twoStopBits = sv_two;
  endtask

  task automatic drive_rx(input logic [15:0] bits, input int nb, input int p);
    for (int i = 0; i < nb; i++) begin
      rx_drv = bits[i];
      cyc(p);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (((exp_q.size() != 0) || rxBusy) && guard < 20000) begin @(posedge clk); guard++; end
    #1;
    check("drain_in_time", {31'd0, guard < 20000}, 32'd1);
  endtask

  task automatic raw_frame(input logic [8:0] d, input logic pbit, input logic sbit, input bit push);
    logic [15:0] bits;
    int n, mode, nb;
    n    = m_bits(int'(dataBits));
    mode = int'(parityMode);
    nb   = m_frame(d, n, mode, 0, pbit, sbit, bits);
    if (push) exp_q.push_back(m_expect(d, n, mode, pbit, sbit));
    drive_rx(bits, nb, m_period(int'(cyclesPerBit)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    rst = 1'b1; enable = 1'b0; txValid = 1'b0; txData = 9'd0;
    loop_en = 1'b1; rx_drv = 1'b1;
    set_cfg(3, 8, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {15'd0, tx, txReady, txBusy, rxValid, rxParityError, rxFramingError, rxBreak, rxBusy, rxData},
          {15'd0, 8'b1000_0000, 9'd0});
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
    check("ready_after_reset", {31'd0, txReady}, 32'd1);
    @(posedge clk); #1;

    // 8N1 0xA5 at 4 clocks/bit, looped back
    send_check(9'h0A5, 1'b1, 1'b0);
    wait_drain();
    // 7E2 0x55
    set_cfg(3, 7, 1, 1);
    send_check(9'h055, 1'b1, 1'b0);
    wait_drain();
    // enable dropped and config scrambled mid-frame: frame completes unchanged
    set_cfg(5, 9, 2, 1);
    send_check(9'h13A, 1'b0, 1'b1);
    cyc(4);
    wait_drain();

    // odd parity with parity bit forced low
    loop_en = 1'b0;
    set_cfg(3, 8, 2, 0);
    raw_frame(9'h00F, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // framing error, then a held break yields exactly one rxValid
    set_cfg(3, 8, 0, 0);
    raw_frame(9'h05A, 1'b0, 1'b0, 1'b1);
    cyc(8);
    exp_q.push_back(m_expect(9'h000, 8, 0, 1'b0, 1'b0));
    rx_drv = 1'b0;
    cyc(20 * 4);
    check("break_wait_high_busy", {31'd0, rxBusy}, 32'd1);
    check("break_single_valid", exp_q.size(), 32'd0);
    rx_drv = 1'b1;
    cyc(4);
    wait_drain();
    raw_frame(9'h0C3, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // one-cycle glitch at 16 clocks/bit, then a real frame
    set_cfg(15, 8, 0, 0);
    rx_drv = 1'b0;
    cyc(1);
    rx_drv = 1'b1;
    busy = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rxBusy) busy++;
    end
    check("glitch_busy_cycles", {31'd0, (busy > 0) && (busy <= 10)}, 32'd1);
    check("glitch_idle", {31'd0, rxBusy}, 32'd0);
    @(posedge clk); #1;
    raw_frame(9'h03C, 1'b0, 1'b1, 1'b1);
    wait_drain();

    // reset during the 3rd data bit of a looped-back frame
    loop_en = 1'b1;
    set_cfg(3, 8, 0, 0);
    txData = 9'h0C3; txValid = 1'b1;
    @(negedge clk);
    check("rst_test_ready", {31'd0, txReady}, 32'd1);
    @(posedge clk); #1;
    txValid = 1'b0;
    cyc(13);
    @(negedge clk);
    check("rx_busy_before_rst", {30'd0, rxBusy, txBusy}, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_frame", {28'd0, tx, txBusy, rxBusy, txReady}, {28'd0, 4'b1000});
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_mid_rst", {31'd0, txReady}, 32'd1);
    @(posedge clk); #1;
    send_check(9'h096, 1'b1, 1'b0);
    wait_drain();

    // randomized loopback frames including out-of-range dataBits and parityMode 3
    for (int it = 0; it < 24; it++) begin
      set_cfg($urandom_range(0, 6), $urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 1));
      send_check(9'($urandom), 1'b1, 1'b0);
      wait_drain();
    end

    cyc(10);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
